// File: rtl/stage4_memory.sv
// ============================================================================
// Module   : stage4_memory
// Purpose  : Pipeline stage 4 -- data-memory access, writeback hand-off and
//            branch forwarding. Optional feature macro: MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage4_memory #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  output logic        stall_o,
  input  logic [31:0] alu_i,
  input  logic        control_load_i,
  input  logic        control_store_i,
  input  logic        control_take_branch_i,
  input  logic        do_wb_i,
  input  logic [3:0]  wb_reg_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic        do_wb_o,
  output logic [3:0]  wb_reg_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        bus_err_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        capture;
  logic        mem_op;
  logic        ack_done;
  logic        timeout_hit;

  logic [31:0] alu_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        do_wb_q;
  logic [3:0]  wb_reg_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("stage4_memory: TIMEOUT_CYCLES must be within 2..255");
  end

  assign stall_o     = stall_i | (state == WAIT);
  assign capture     = ~stall_o;
  assign mem_op      = control_load_i | control_store_i;

  assign mem_req_o   = (state == WAIT);
  assign mem_we_o    = (state == WAIT) & we_q;
  assign mem_addr_o  = alu_q;
  assign mem_wdata_o = wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Ack wins over a coincident timeout; mem_ack_i is meaningless in IDLE.
  always_comb begin
    state_nxt   = state;
    ack_done    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (capture && mem_op) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_ack_i) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      alu_q           <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      do_wb_q         <= 1'b0;
      wb_reg_q        <= '0;
      wb_data_o       <= '0;
      do_wb_o         <= 1'b0;
      wb_reg_o        <= '0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
    end else if (capture) begin
      alu_q           <= alu_i;
      we_q            <= control_store_i;
      wdata_q         <= store_data_i;
      do_wb_q         <= do_wb_i;
      wb_reg_q        <= wb_reg_i;
      branch_taken_o  <= control_take_branch_i;
      branch_target_o <= alu_i;
      if (mem_op) begin
        // Bubble towards stage 5 while the access is outstanding.
        do_wb_o <= 1'b0;
      end else begin
        wb_data_o <= alu_i;
        do_wb_o   <= do_wb_i;
        wb_reg_o  <= wb_reg_i;
      end
    end else if (ack_done) begin
      wb_data_o <= we_q ? alu_q : mem_rdata_i;
      do_wb_o   <= do_wb_q;
      wb_reg_o  <= wb_reg_q;
    end else if (timeout_hit) begin
      wb_data_o <= 32'hDEADBEEF;
      do_wb_o   <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_cnt   <= '0;
      bus_err_o <= 1'b0;
    end else begin
      if (state == IDLE)    tmo_cnt <= '0;
      else if (!mem_ack_i)  tmo_cnt <= tmo_cnt + 8'd1;
      if (timeout_hit)      bus_err_o <= 1'b1;
    end
  end
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage4_memory.sv
// Directed test of stage4_memory: ALU pass-through, load/store handshakes,
// stalled ack, reset mid-access and the timeout (or no-timeout) behaviour.
`default_nettype none

module tb_stage4_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        stall_out;
  logic [31:0] alu;
  logic        ld, st, tb_br;
  logic        do_wb_in;
  logic [3:0]  wb_reg_in;
  logic [31:0] sdata;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] wb_data;
  logic        do_wb_out;
  logic [3:0]  wb_reg_out;
  logic        br_taken;
  logic [31:0] br_target;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage4_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .stall_i               (stall_in),
    .stall_o               (stall_out),
    .alu_i                 (alu),
    .control_load_i        (ld),
    .control_store_i       (st),
    .control_take_branch_i (tb_br),
    .do_wb_i               (do_wb_in),
    .wb_reg_i              (wb_reg_in),
    .store_data_i          (sdata),
    .mem_req_o             (req),
    .mem_we_o              (we),
    .mem_addr_o            (addr),
    .mem_wdata_o           (wdata),
    .mem_ack_i             (ack),
    .mem_rdata_i           (rdata),
    .wb_data_o             (wb_data),
    .do_wb_o               (do_wb_out),
    .wb_reg_o              (wb_reg_out),
    .branch_taken_o        (br_taken),
    .branch_target_o       (br_target),
    .bus_err_o             (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    alu = 32'h0; ld = 1'b0; st = 1'b0; tb_br = 1'b0;
    do_wb_in = 1'b0; wb_reg_in = 4'h0; sdata = 32'h0;
  endtask

  // Runs the WAIT phase of an already-captured access, asserting ack on the
  // ack_at-th request cycle (0-based); reports request and stall cycle counts.
  task automatic run_access(input int ack_at, input logic [31:0] ack_data,
                            output int req_cycles, output int stall_cycles);
    req_cycles   = 0;
    stall_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!req) break;
      req_cycles++;
      if (stall_out) stall_cycles++;
      ack   = (c == ack_at);
      rdata = ack_data;
      tick();
      ack = 1'b0;
    end
  endtask

  int rq, sc;

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; ack = 1'b0; rdata = 32'h0;
    bubble();
    alu = 32'hFFFF_FFFF; do_wb_in = 1'b1; st = 1'b1;
    tick(); tick();
    check("rst_wb_data",  wb_data,   32'h0);
    check("rst_do_wb",    do_wb_out, 0);
    check("rst_req",      req,       0);
    check("rst_addr",     addr,      32'h0);
    check("rst_br_tgt",   br_target, 32'h0);
    check("rst_bus_err",  bus_err,   0);
    bubble();
    rst_n = 1'b1;
    tick();

    // ALU op with a taken branch
    alu = 32'h12; do_wb_in = 1'b1; wb_reg_in = 4'd3; tb_br = 1'b1;
    check("alu_stall_pre", stall_out, 0);
    tick();
    bubble();
    check("alu_wb_data",  wb_data,    32'h12);
    check("alu_do_wb",    do_wb_out,  1);
    check("alu_wb_reg",   wb_reg_out, 32'd3);
    check("alu_stall",    stall_out,  0);
    check("alu_br_taken", br_taken,   1);
    check("alu_br_tgt",   br_target,  32'h12);

    // Load, ack two cycles after the first request cycle
    alu = 32'h100; ld = 1'b1; do_wb_in = 1'b1; wb_reg_in = 4'd5;
    tick();
    bubble();
    alu = 32'h999;
    check("ld_addr",  addr, 32'h100);
    check("ld_we",    we,   0);
    run_access(2, 32'hCAFEF00D, rq, sc);
    check("ld_req_cycles",   rq, 3);
    check("ld_stall_cycles", sc, 3);
    check("ld_wb_data", wb_data,    32'hCAFEF00D);
    check("ld_do_wb",   do_wb_out,  1);
    check("ld_wb_reg",  wb_reg_out, 32'd5);
    check("ld_stall_after", stall_out, 0);
    bubble();
    tick();

    // Zero-wait store
    alu = 32'h200; st = 1'b1; sdata = 32'h55;
    tick();
    bubble();
    check("st_we",    we,    1);
    check("st_wdata", wdata, 32'h55);
    run_access(0, 32'h0, rq, sc);
    check("st_req_cycles",   rq, 1);
    check("st_stall_cycles", sc, 1);
    check("st_wb_data", wb_data, 32'h200);
    check("st_we_idle", we,      0);

    // Load and store together behave as a store
    alu = 32'h600; ld = 1'b1; st = 1'b1; sdata = 32'h77;
    tick();
    bubble();
    check("ldst_we", we, 1);
    run_access(0, 32'hBAD0BAD0, rq, sc);
    check("ldst_wb_data", wb_data, 32'h600);

    // Ack while stage 5 stalls
    alu = 32'h300; ld = 1'b1; do_wb_in = 1'b1; wb_reg_in = 4'd7;
    tick();
    bubble();
    check("sack_req", req, 1);
    stall_in = 1'b1; ack = 1'b1; rdata = 32'h1234_5678;
    tick();
    ack = 1'b0;
    check("sack_req_drop", req,       0);
    check("sack_wb_data",  wb_data,   32'h1234_5678);
    check("sack_stall_hi", stall_out, 1);
    tick();
    check("sack_no_rereq", req, 0);
    stall_in = 1'b0;
    #1;
    check("sack_stall_lo", stall_out, 0);
    tick();

    // Reset mid-WAIT followed by a late ack
    alu = 32'h400; ld = 1'b1; tb_br = 1'b1; do_wb_in = 1'b1;
    tick();
    bubble();
    check("rw_req", req, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ack = 1'b1; rdata = 32'hFEED_FACE;
    check("rw_req_off",  req,       0);
    check("rw_wb_data",  wb_data,   32'h0);
    check("rw_br_taken", br_taken,  0);
    check("rw_stall",    stall_out, 0);
    tick();
    ack = 1'b0;
    check("rw_late_req",  req,     0);
    check("rw_late_data", wb_data, 32'h0);

    // No-ack access: abort after 4 cycles with the timeout, else wait on
    alu = 32'h500; ld = 1'b1; do_wb_in = 1'b1;
    tick();
    bubble();
`ifdef MEM_TIMEOUT_EN
    run_access(-1, 32'h0, rq, sc);
    check("to_req_cycles", rq,        4);
    check("to_bus_err",    bus_err,   1);
    check("to_wb_data",    wb_data,   32'hDEADBEEF);
    check("to_do_wb",      do_wb_out, 0);
    check("to_stall",      stall_out, 0);
    tick();
    check("to_bus_err_sticky", bus_err, 1);
`else
    rq = 0;
    for (int c = 0; c < 20; c++) begin
      if (req) rq++;
      tick();
    end
    check("nto_req_cycles", rq,      20);
    check("nto_bus_err",    bus_err, 0);
    ack = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    ack = 1'b0;
    check("nto_req_done", req,     0);
    check("nto_wb_data",  wb_data, 32'h0BAD_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage4_memory.md
STAGE4_MEMORY -- requirements
Module: stage4_memory

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning WAIT cycles without ack before abort (used only with MEM_TIMEOUT_EN; legal range 2..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port stall_i  input  1  stall from stage 5.
REQ-005 SHALL have port stall_o  output  1  stall to stage 3.
REQ-006 SHALL have ports alu_i  input  32, control_load_i  input  1, control_store_i  input  1, control_take_branch_i  input  1, do_wb_i  input  1, wb_reg_i  input  4, store_data_i  input  32; all from stage 3.
REQ-007 SHALL have ports mem_req_o  output  1, mem_we_o  output  1, mem_addr_o  output  32, mem_wdata_o  output  32, mem_ack_i  input  1, mem_rdata_i  input  32; data memory bus.
REQ-008 SHALL have ports wb_data_o  output  32, do_wb_o  output  1, wb_reg_o  output  4; to stage 5.
REQ-009 SHALL have ports branch_taken_o  output  1, branch_target_o  output  32; to stage 1.
REQ-010 SHALL have port bus_err_o  output  1  sticky bus-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT; stall_o = stall_i OR (state==WAIT), combinational.
REQ-012 SHALL, in any cycle with stall_o low, capture all stage-3 inputs into internal registers; with stall_o high, hold every register, except as REQ-015/REQ-016 allow.
REQ-013 SHALL, on capture with control_load_i or control_store_i high, enter WAIT next cycle; otherwise stay IDLE with wb_data_o=alu_i, do_wb_o=do_wb_i, wb_reg_o=wb_reg_i (1-cycle latency).
REQ-014 SHALL, in WAIT, drive mem_req_o=1, mem_addr_o=captured alu, mem_we_o=captured store flag, mem_wdata_o=captured store_data; in IDLE mem_req_o=0, mem_we_o=0.
REQ-015 SHALL, on a WAIT cycle with mem_ack_i=1, return to IDLE next cycle; for a load, load wb_data_o<=mem_rdata_i; for a store, wb_data_o<=captured alu; do_wb_o/wb_reg_o from captured values.
REQ-016 SHALL drop mem_req_o after ack even if stall_i is high; a WAIT-to-IDLE transition takes priority over stall_i.
REQ-017 SHALL give each load/store at least one stall_o cycle (the ack cycle included); zero-wait ack yields exactly 1 stall cycle.
REQ-018 SHALL treat control_load_i and control_store_i both high as a store.
REQ-019 SHALL register branch_taken_o<=control_take_branch_i and branch_target_o<=alu_i on capture.
REQ-020 SHALL ignore mem_ack_i in IDLE.

Reset
REQ-021 SHALL, with rst_n_i low at a clock edge, set state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, wb_data_o=0, do_wb_o=0, wb_reg_o=0, branch_taken_o=0, branch_target_o=0, bus_err_o=0, timeout counter=0, overriding stall and ack.
REQ-022 SHALL abandon an in-flight access on reset mid-WAIT (mem_req_o low the next cycle); late ack after reset ignored per REQ-020.

Configuration
REQ-023 SHALL, with MEM_TIMEOUT_EN defined, count WAIT cycles (8-bit, cleared on WAIT entry); at TIMEOUT_CYCLES WAIT cycles without ack, go IDLE, set bus_err_o (sticky until reset), wb_data_o=32'hDEADBEEF, do_wb_o=0.
REQ-024 SHALL, without MEM_TIMEOUT_EN, wait indefinitely in WAIT, omit the counter, tie bus_err_o to 0.

Verification
REQ-025 ALU op: alu_i=32'h12, do_wb_i=1, wb_reg_i=3, no stall -> next cycle wb_data_o=32'h12, do_wb_o=1, wb_reg_o=3, stall_o never high.
REQ-026 Load, ack 2 cycles after req: alu_i=32'h100 -> mem_req_o high 3 cycles at addr 32'h100, mem_we_o=0, stall_o high 3 cycles, wb_data_o=mem_rdata_i (32'hCAFEF00D) after ack.
REQ-027 Store zero-wait: alu_i=32'h200, store_data_i=32'h55 -> mem_we_o=1, mem_wdata_o=32'h55 one cycle, stall_o high exactly 1 cycle.
REQ-028 Ack with stall_i=1 -> mem_req_o low next cycle, load data latched, stall_o tracks stall_i thereafter, no second request.
REQ-029 Reset mid-WAIT, then ack -> all outputs zero, mem_req_o stays 0, state IDLE.
REQ-030 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> 4 req cycles, then bus_err_o=1, wb_data_o=32'hDEADBEEF, do_wb_o=0, stall_o released.
